// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding mux, load-use bubble insertion and flush/hold.
// Optional bubble counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_write_register,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      id_memwrite,
    input  logic                      id_memtoreg,
    input  logic                      id_alusrc,
    input  logic [ALUOP_WIDTH-1:0]    id_aluop,
    input  logic [1:0]                forward_a,
    input  logic [1:0]                forward_b,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    output logic                      stall,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_rs_data,
    output logic [DATA_WIDTH-1:0]     ex_rt_data,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_write_register,
    output logic                      ex_regwrite,
    output logic                      ex_memread,
    output logic                      ex_memwrite,
    output logic                      ex_memtoreg,
    output logic                      ex_alusrc,
    output logic [ALUOP_WIDTH-1:0]    ex_aluop,
    output logic [31:0]               stall_count
);

    logic [DATA_WIDTH-1:0] rs_fwd;
    logic [DATA_WIDTH-1:0] rt_fwd;
    logic                  load_use;
    logic                  bubble;

    always_comb begin
        rs_fwd = id_rs_data;
        case (forward_a)
            2'b10:   rs_fwd = ex_alu_result;
            2'b01:   rs_fwd = mem_result;
            default: rs_fwd = id_rs_data;
        endcase
    end

    always_comb begin
        rt_fwd = id_rt_data;
        case (forward_b)
            2'b10:   rt_fwd = ex_alu_result;
            2'b01:   rt_fwd = mem_result;
            default: rt_fwd = id_rt_data;
        endcase
    end

    // $0 is hard-wired, so a load targeting it can never create a real dependency
    assign load_use = ex_valid & ex_memread & (ex_write_register != '0)
                    & ((ex_write_register == id_rs) | (ex_write_register == id_rt))
                    & id_valid;
    assign stall    = (load_use | hold) & ~reset;
    assign bubble   = flush | load_use | ~id_valid;

    always_ff @(posedge clk) begin
        if (reset || (!hold && bubble)) begin
            ex_valid          <= 1'b0;
            ex_rs_data        <= '0;
            ex_rt_data        <= '0;
            ex_imm            <= '0;
            ex_write_register <= '0;
            ex_regwrite       <= 1'b0;
            ex_memread        <= 1'b0;
            ex_memwrite       <= 1'b0;
            ex_memtoreg       <= 1'b0;
            ex_alusrc         <= 1'b0;
            ex_aluop          <= '0;
        end else if (!hold) begin
            ex_valid          <= 1'b1;
            ex_rs_data        <= rs_fwd;
            ex_rt_data        <= rt_fwd;
            ex_imm            <= id_imm;
            ex_write_register <= id_write_register;
            ex_regwrite       <= id_regwrite;
            ex_memread        <= id_memread;
            ex_memwrite       <= id_memwrite;
            ex_memtoreg       <= id_memtoreg;
            ex_alusrc         <= id_alusrc;
            ex_aluop          <= id_aluop;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Only hazard/flush bubbles count; an idle ID slot is not a stall
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (!hold && (flush || load_use))
            stall_count <= stall_count + 32'd1;
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: stimulus pushes expectations, a negedge monitor checks them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_write_register;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
    logic [3:0]  id_aluop;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] ex_alu_result, mem_result;
    logic        stall, ex_valid;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_write_register;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
    logic [3:0]  ex_aluop;
    logic [31:0] stall_count;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_write_register(id_write_register),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
        .forward_a(forward_a), .forward_b(forward_b),
        .ex_alu_result(ex_alu_result), .mem_result(mem_result),
        .stall(stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_write_register(ex_write_register),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic        stall;
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  wr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (stall !== e.stall || ex_valid !== e.valid || ex_regwrite !== e.rw ||
                         ex_memread !== e.mr || ex_memwrite !== e.mw || ex_rs_data !== e.rs ||
                         ex_rt_data !== e.rt || ex_write_register !== e.wr || stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s: got stall=%0b v=%0b rw=%0b mr=%0b mw=%0b rs=%h rt=%h wr=%0d cnt=%0d; want stall=%0b v=%0b rw=%0b mr=%0b mw=%0b rs=%h rt=%h wr=%0d cnt=%0d",
                         e.name, stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite,
                         ex_rs_data, ex_rt_data, ex_write_register, stall_count,
                         e.stall, e.valid, e.rw, e.mr, e.mw, e.rs, e.rt, e.wr, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic mw,
                       input logic [1:0] fa, input logic [1:0] fb);
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd;
        id_write_register = wr; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
        id_memtoreg = mr; id_alusrc = mr | mw; id_aluop = wr[3:0]; id_imm = rsd ^ 32'h1;
        forward_a = fa; forward_b = fb;
    endtask

    task automatic expect_now(input string name, input logic st, input logic v, input logic rw,
                              input logic mr, input logic mw, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [4:0] wr);
        exp_t e;
        e.cyc = cyc; e.name = name; e.stall = st; e.valid = v; e.rw = rw; e.mr = mr;
        e.mw = mw; e.rs = rs; e.rt = rt; e.wr = wr; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic count_bubble();
`ifdef ID_EX_STALL_CNT_EN
        exp_cnt = exp_cnt + 1;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; hold = 0; flush = 0;
        ex_alu_result = 32'h11; mem_result = 32'h22;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        tick(); tick();
        reset = 0;
        expect_now("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(1, 1, 2, 32'h33, 32'h44, 3, 1, 0, 0, 2'b10, 2'b01);
        expect_now("idle_bubble", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(1, 4, 5, 32'h33, 32'h44, 6, 1, 0, 0, 2'b00, 2'b11);
        expect_now("fwd_ex_mem", 0, 1, 1, 0, 0, 32'h11, 32'h22, 3);
        tick();
        drv(1, 9, 10, 32'h100, 32'h200, 8, 1, 1, 0, 2'b00, 2'b00);
        expect_now("fwd_regfile", 0, 1, 1, 0, 0, 32'h33, 32'h44, 6);
        tick();
        drv(1, 8, 2, 32'h55, 32'h66, 11, 1, 0, 0, 2'b00, 2'b00);
        expect_now("lw_stall", 1, 1, 1, 1, 0, 32'h100, 32'h200, 8);
        tick(); count_bubble();
        drv(1, 8, 2, 32'h55, 32'h66, 11, 1, 0, 0, 2'b01, 2'b00);
        expect_now("load_use_bubble", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(1, 1, 2, 32'h77, 32'h88, 0, 1, 1, 0, 2'b00, 2'b00);
        expect_now("consumer_loads", 0, 1, 1, 0, 0, 32'h22, 32'h66, 11);
        tick();
        drv(1, 0, 0, 32'h99, 32'hAA, 12, 1, 0, 0, 2'b00, 2'b00);
        expect_now("lw_r0_no_stall", 0, 1, 1, 1, 0, 32'h77, 32'h88, 0);
        tick();
        drv(1, 1, 2, 32'h1, 32'h2, 0, 0, 0, 1, 2'b00, 2'b00);
        flush = 1;
        expect_now("r0_consumer_loads", 0, 1, 1, 0, 0, 32'h99, 32'hAA, 12);
        tick(); count_bubble();
        flush = 0;
        drv(1, 1, 2, 32'h10, 32'h20, 7, 1, 1, 0, 2'b00, 2'b00);
        expect_now("flush_bubble", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(1, 7, 3, 32'h30, 32'h40, 13, 1, 0, 0, 2'b00, 2'b00);
        flush = 1;
        expect_now("lw7_stall", 1, 1, 1, 1, 0, 32'h10, 32'h20, 7);
        tick(); count_bubble();
        flush = 0;
        expect_now("flush_and_load_use", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drv(1, 1, 2, 32'h5, 32'h6, 14, 1, 0, 0, 2'b00, 2'b00);
        expect_now("reissue_loads", 0, 1, 1, 0, 0, 32'h30, 32'h40, 13);
        tick();
        hold = 1; flush = 1;
        drv(1, 1, 2, 32'hE0, 32'hF0, 15, 1, 0, 0, 2'b00, 2'b00);
        expect_now("hold_start", 1, 1, 1, 0, 0, 32'h5, 32'h6, 14);
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_now("hold_keep", 1, 1, 1, 0, 0, 32'h5, 32'h6, 14);
        end
        tick();
        hold = 0;
        expect_now("hold_release", 0, 1, 1, 0, 0, 32'h5, 32'h6, 14);
        tick(); count_bubble();
        flush = 0;
        expect_now("flush_after_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        hold = 1;
        expect_now("k_loaded", 1, 1, 1, 0, 0, 32'hE0, 32'hF0, 15);
        tick();
        reset = 1;
        expect_now("reset_masks_stall", 0, 1, 1, 0, 0, 32'hE0, 32'hF0, 15);
        tick();
        reset = 0; hold = 0; exp_cnt = 0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        expect_now("reset_during_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
